// File: rtl/param_deserializer.sv
// param_deserializer
//   Collects DATA_WIDTH payload bits from an oversampled serial line into a
//   parallel word. One bit is captured per bit period, on the clock where
//   edge_count reaches (Prescale/2)+2 while deser_en is high. Bit order is
//   chosen per frame from lsb_first, sampled on the frame's first bit.
//
//   Optional feature macro: DESER_PARITY_EN
//     defined   : par_calc = (XOR of completed word) XOR par_type,
//                 loaded together with P_DATA
//     undefined : par_calc tied to 0, par_type unused
//
// Ports
//   clk         in   sole clock, rising edge
//   rst         in   asynchronous reset, active low
//   sampled_bit in   majority-voted line value
//   deser_en    in   payload window enable; low discards a partial frame
//   lsb_first   in   1 = LSB first, 0 = MSB first
//   par_type    in   0 = even, 1 = odd (parity build only)
//   Prescale    in   oversampling ratio
//   edge_count  in   edge position within the current bit
//   P_DATA      out  last completed word
//   data_valid  out  one-cycle pulse after a word completes
//   bit_cnt     out  payload bits captured in the current frame
//   par_calc    out  parity of P_DATA
module param_deserializer #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 6,
  parameter int CNT_WIDTH   = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sampled_bit,
  input  logic                   deser_en,
  input  logic                   lsb_first,
  input  logic                   par_type,
  input  logic [PRESC_WIDTH-1:0] Prescale,
  input  logic [CNT_WIDTH-1:0]   edge_count,
  output logic [DATA_WIDTH-1:0]  P_DATA,
  output logic                   data_valid,
  output logic [3:0]             bit_cnt,
  output logic                   par_calc
);

  localparam int CMP_W = ((PRESC_WIDTH > CNT_WIDTH) ? PRESC_WIDTH : CNT_WIDTH) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic                  order_q;
  logic                  order_eff;
  logic [CMP_W-1:0]      target;
  logic [CMP_W-1:0]      edge_ext;
  logic                  strobe;
  logic                  last_bit;

  // Both operands zero-extended to a common width with one bit of headroom
  // so the +2 cannot wrap.
  assign target   = CMP_W'(Prescale >> 1) + CMP_W'(2);
  assign edge_ext = CMP_W'(edge_count);
  assign strobe   = deser_en && (edge_ext == target);

  // First bit of a frame uses the live lsb_first; later bits use the value
  // latched on that first strobe.
  assign order_eff  = (bit_cnt == 4'd0) ? lsb_first : order_q;
  assign shift_next = order_eff ? {sampled_bit, shift_reg[DATA_WIDTH-1:1]}
                                : {shift_reg[DATA_WIDTH-2:0], sampled_bit};
  assign last_bit   = (bit_cnt == 4'(DATA_WIDTH - 1));

  assign data_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      P_DATA    <= '0;
      order_q   <= 1'b1;
    end else if (!deser_en) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        IDLE, SHIFT, DONE: state <= SHIFT;
        default:           state <= IDLE;
      endcase
      if (strobe) begin
        if (bit_cnt == 4'd0) begin
          order_q <= lsb_first;
        end
        shift_reg <= shift_next;
        if (last_bit) begin
          bit_cnt <= '0;
          P_DATA  <= shift_next;
          state   <= DONE;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
    end
  end

`ifdef DESER_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_calc <= 1'b0;
    end else if (strobe && last_bit) begin
      par_calc <= (^shift_next) ^ par_type;
    end
  end
`else
  logic unused_par_type;
  assign unused_par_type = par_type;
  assign par_calc        = 1'b0;
`endif

endmodule

// File: tb/tb_param_deserializer.sv
// Self-checking bench for param_deserializer (DATA_WIDTH=8, PRESC_WIDTH=6,
// CNT_WIDTH=5). Inputs change on falling edges; outputs are read on falling
// edges. Expected words come from a bit-stream model, not the RTL structure.
module tb_param_deserializer;

  localparam int W    = 8;
  localparam int PW   = 6;
  localparam int CNTW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sampled_bit = 1'b0;
  logic          deser_en = 1'b0;
  logic          lsb_first = 1'b1;
  logic          par_type = 1'b0;
  logic [PW-1:0] Prescale = 6'd8;
  logic [CNTW-1:0] edge_count = '0;
  logic [W-1:0]  P_DATA;
  logic          data_valid;
  logic [3:0]    bit_cnt;
  logic          par_calc;

  int total = 0;
  int bad   = 0;

  int           dv_count = 0;
  int           dv_double = 0;
  int           pdata_glitch = 0;
  logic         prev_dv = 1'b0;
  logic [W-1:0] prev_pdata = '0;

  always #5 clk = ~clk;

  param_deserializer #(
    .DATA_WIDTH (W),
    .PRESC_WIDTH(PW),
    .CNT_WIDTH  (CNTW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sampled_bit(sampled_bit),
    .deser_en   (deser_en),
    .lsb_first  (lsb_first),
    .par_type   (par_type),
    .Prescale   (Prescale),
    .edge_count (edge_count),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .bit_cnt    (bit_cnt),
    .par_calc   (par_calc)
  );

  // Pulse / stability watcher
  always @(negedge clk) begin
    if (!rst) begin
      prev_dv    = 1'b0;
      prev_pdata = P_DATA;
    end else begin
      if (data_valid) dv_count++;
      if (data_valid && prev_dv) dv_double++;
      if (P_DATA !== prev_pdata && !data_valid) pdata_glitch++;
      prev_dv    = data_valid;
      prev_pdata = P_DATA;
    end
  end

  // Reference: stream[i] is the i-th transmitted bit.
  function automatic logic [W-1:0] model_word(input logic [W-1:0] stream, input logic order);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (order) w[i] = stream[i];
      else       w[W-1-i] = stream[i];
    end
    return w;
  endfunction

  function automatic logic model_par(input logic [W-1:0] w, input logic pt);
`ifdef DESER_PARITY_EN
    int ones;
    ones = 0;
    for (int i = 0; i < W; i++) ones += int'(w[i]);
    return logic'((ones % 2) != 0) ^ pt;
`else
    return 1'b0;
`endif
  endfunction

  // Drives nbits bit periods, one clock per edge_count value, then one
  // extra clock so a completion pulse at the final edge has been seen.
  task automatic send_frame(input logic [W-1:0] stream, input int nbits,
                            input logic order, input int toggle_at);
    for (int i = 0; i < nbits; i++) begin
      for (int e = 0; e < int'(Prescale); e++) begin
        deser_en    = 1'b1;
        sampled_bit = stream[i];
        edge_count  = CNTW'(e);
        lsb_first   = (toggle_at >= 0 && i >= toggle_at) ? ~order : order;
        @(negedge clk);
      end
    end
    edge_count = '0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (P_DATA !== 8'h00) begin bad++; $display("FAIL reset_pdata got=%h exp=00", P_DATA); end
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_dv got=%b exp=0", data_valid); end
    total++; if (bit_cnt !== 4'd0) begin bad++; $display("FAIL reset_bitcnt got=%0d exp=0", bit_cnt); end
    total++; if (par_calc !== 1'b0) begin bad++; $display("FAIL reset_par got=%b exp=0", par_calc); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lsb_first();
    int dv0;
    Prescale = 6'd8;
    par_type = 1'b0;
    dv0 = dv_count;
    send_frame(8'h1B, W, 1'b1, -1);
    total++; if (P_DATA !== 8'h1B) begin bad++; $display("FAIL lsb_pdata got=%h exp=1b", P_DATA); end
    total++; if (dv_count - dv0 != 1) begin bad++; $display("FAIL lsb_dv_pulses got=%0d exp=1", dv_count - dv0); end
    total++; if (bit_cnt !== 4'd0) begin bad++; $display("FAIL lsb_bitcnt got=%0d exp=0", bit_cnt); end
    total++; if (par_calc !== model_par(8'h1B, 1'b0)) begin bad++; $display("FAIL par_even got=%b exp=%b", par_calc, model_par(8'h1B, 1'b0)); end
    par_type = 1'b1;
    send_frame(8'h1B, W, 1'b1, -1);
    total++; if (par_calc !== model_par(8'h1B, 1'b1)) begin bad++; $display("FAIL par_odd got=%b exp=%b", par_calc, model_par(8'h1B, 1'b1)); end
    deser_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_msb_first();
    send_frame(8'h1B, W, 1'b0, -1);
    total++; if (P_DATA !== 8'hD8) begin bad++; $display("FAIL msb_pdata got=%h exp=d8", P_DATA); end
    deser_en = 1'b0;
    @(negedge clk);
    send_frame(8'h1B, W, 1'b0, 2);
    total++; if (P_DATA !== 8'hD8) begin bad++; $display("FAIL msb_toggle_pdata got=%h exp=d8", P_DATA); end
    deser_en  = 1'b0;
    lsb_first = 1'b1;
    @(negedge clk);
  endtask

  task automatic scan_strobe(input int presc);
    int target;
    Prescale = PW'(presc);
    target   = presc / 2 + 2;
    for (int e = 0; e < 32; e++) begin
      deser_en = 1'b0;
      @(negedge clk);
      deser_en   = 1'b1;
      edge_count = CNTW'(e);
      @(negedge clk);
      total++;
      if (bit_cnt !== ((e == target) ? 4'd1 : 4'd0)) begin
        bad++;
        $display("FAIL strobe_p%0d_e%0d got=%0d exp=%0d", presc, e, bit_cnt, (e == target) ? 1 : 0);
      end
    end
    deser_en   = 1'b0;
    edge_count = '0;
    @(negedge clk);
  endtask

  task automatic test_strobe_position();
    scan_strobe(5);
    scan_strobe(16);
    scan_strobe(int'($urandom_range(4, 58)));
    scan_strobe(int'($urandom_range(4, 58)));
  endtask

  task automatic test_abort();
    int dv0;
    logic [W-1:0] p0;
    Prescale = 6'd8;
    p0  = P_DATA;
    dv0 = dv_count;
    send_frame(8'hFF, 3, 1'b1, -1);
    deser_en = 1'b0;
    @(negedge clk);
    total++; if (bit_cnt !== 4'd0) begin bad++; $display("FAIL abort_bitcnt got=%0d exp=0", bit_cnt); end
    total++; if (P_DATA !== p0) begin bad++; $display("FAIL abort_pdata_hold got=%h exp=%h", P_DATA, p0); end
    total++; if (dv_count != dv0) begin bad++; $display("FAIL abort_dv got=%0d exp=0", dv_count - dv0); end
    send_frame(8'h5A, W, 1'b1, -1);
    total++; if (P_DATA !== 8'h5A) begin bad++; $display("FAIL abort_next_pdata got=%h exp=5a", P_DATA); end
    total++; if (bit_cnt !== 4'd0) begin bad++; $display("FAIL abort_next_bitcnt got=%0d exp=0", bit_cnt); end
    total++; if (dv_count - dv0 != 1) begin bad++; $display("FAIL abort_next_dv got=%0d exp=1", dv_count - dv0); end
  endtask

  task automatic test_reset_midframe();
    int dv0;
    send_frame(8'h00, 4, 1'b1, -1);
    #2 rst = 1'b0;
    #1;
    total++; if (P_DATA !== 8'h00) begin bad++; $display("FAIL arst_pdata got=%h exp=00", P_DATA); end
    total++; if (bit_cnt !== 4'd0) begin bad++; $display("FAIL arst_bitcnt got=%0d exp=0", bit_cnt); end
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL arst_dv got=%b exp=0", data_valid); end
    total++; if (par_calc !== 1'b0) begin bad++; $display("FAIL arst_par got=%b exp=0", par_calc); end
    deser_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    dv0 = dv_count;
    send_frame(8'hFF, W, 1'b1, -1);
    total++; if (P_DATA !== 8'hFF) begin bad++; $display("FAIL arst_next_pdata got=%h exp=ff", P_DATA); end
    total++; if (dv_count - dv0 != 1) begin bad++; $display("FAIL arst_next_dv got=%0d exp=1", dv_count - dv0); end
    deser_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int dv0;
    int tog;
    logic [W-1:0] stream;
    logic order;
    logic [W-1:0] exp_w;
    for (int f = 0; f < 20; f++) begin
      Prescale = PW'($urandom_range(5, 16));
      stream   = W'($urandom);
      order    = logic'($urandom_range(0, 1));
      par_type = logic'($urandom_range(0, 1));
      tog      = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, W - 1)) : -1;
      exp_w    = model_word(stream, order);
      dv0      = dv_count;
      send_frame(stream, W, order, tog);
      total++; if (P_DATA !== exp_w) begin bad++; $display("FAIL b2b_pdata_%0d got=%h exp=%h", f, P_DATA, exp_w); end
      total++; if (par_calc !== model_par(exp_w, par_type)) begin bad++; $display("FAIL b2b_par_%0d got=%b exp=%b", f, par_calc, model_par(exp_w, par_type)); end
      total++; if (dv_count - dv0 != 1) begin bad++; $display("FAIL b2b_dv_%0d got=%0d exp=1", f, dv_count - dv0); end
      if ($urandom_range(0, 3) == 0) begin
        deser_en = 1'b0;
        @(negedge clk);
      end
    end
    deser_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_integrity();
    total++; if (dv_double != 0) begin bad++; $display("FAIL dv_multi_cycle got=%0d exp=0", dv_double); end
    total++; if (pdata_glitch != 0) begin bad++; $display("FAIL pdata_unexpected_change got=%0d exp=0", pdata_glitch); end
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_strobe_position();
    test_abort();
    test_reset_midframe();
    test_back_to_back();
    test_integrity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
